trdb_stage_ctrl: RTL and testbench

- Sequences the retired-instruction stream into the last/this/next (lc/tc/nc) stage registers that feed the itype detector.
- Drives the detector's tc_ready/nc_ready qualifiers and holds the stages stable while the packet emitter is busy.
- Drops replayed retirements at the same address and drains the pipe cleanly when tracing is disabled.
- Sits between the core retire interface and the itype detector / packet emitter.

---
 rtl/trdb_pkg.sv | 31 +++
 rtl/trdb_stage_reg.sv | 35 +++
 rtl/trdb_stage_ctrl.sv | 172 +++++++++++++++++
 tb/tb_trdb_stage_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/trdb_pkg.sv
// Shared types for the trace stage controller: FSM states, the stage record
// carried through lc/tc/nc, and a helper that retires a stage in place.
package trdb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } trdb_stage_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] iaddr;
        logic [XLEN-1:0] inst_data;
        logic            compressed;
        logic            exception;
    } trdb_stage_t;

    // Drop the valid bit but keep the payload, so a stage that empties out
    // leaves its last data visible and unchanged.
    function automatic trdb_stage_t stage_invalidate(input trdb_stage_t s);
        trdb_stage_t r;
        r       = s;
        r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/trdb_stage_reg.sv
// One pipeline stage of the retired-instruction window. Loads d_i when en_i
// is high and otherwise holds; synchronous active-low reset clears it.
module trdb_stage_reg
    import trdb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  trdb_stage_t d_i,
    output trdb_stage_t q_o
);

    trdb_stage_t stage_q;
    trdb_stage_t stage_d;

    // Next value: load on enable, otherwise hold.
    always_comb begin
        stage_d = stage_q;
        if (en_i) begin
            stage_d = d_i;
        end
    end

    // Stage register with synchronous reset to all-zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/trdb_stage_ctrl.sv
// Sequences retired instructions into the lc/tc/nc stage window feeding the
// itype detector. Handshakes: a retire beat transfers when inst_valid_i and
// inst_ready_o are both high at a clk_i edge; a step transfers when
// step_valid_o and step_ready_i are both high. Valid never depends on ready
// from the same interface, and the stage window is frozen while a step is
// offered but not taken.
module trdb_stage_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            inst_valid_i,
    output logic            inst_ready_o,
    input  logic [XLEN-1:0] inst_data_i,
    input  logic [XLEN-1:0] iaddr_i,
    input  logic            compressed_i,
    input  logic            exception_i,
    output logic            lc_valid_o,
    output logic            tc_ready_o,
    output logic            nc_ready_o,
    output logic [XLEN-1:0] tc_iaddr_o,
    output logic            tc_compressed_o,
    output logic [XLEN-1:0] nc_iaddr_o,
    output logic [XLEN-1:0] nc_inst_data_o,
    output logic            nc_exception_o,
    output logic            step_valid_o,
    input  logic            step_ready_i,
    output logic            first_o,
    output logic            last_o
);

    import trdb_pkg::*;

    trdb_stage_state_e state_q, state_d;
    logic              first_q, first_d;
    trdb_stage_t       lc_q, tc_q, nc_q;
    trdb_stage_t       lc_d, tc_d, nc_d;
    trdb_stage_t       beat;
    logic              stage_en;
    logic              step_valid;
    logic              shift_en;
    logic              step_hs;
    logic              inst_ready;
    logic              accept;
    logic              dup;
    logic              last;

    // Handshake qualifiers derived from the registered window.
    always_comb begin
        step_valid = tc_q.valid && (nc_q.valid || (state_q == DRAIN));
        shift_en   = !step_valid || step_ready_i;
        step_hs    = step_valid && step_ready_i;
        last       = step_valid && !nc_q.valid;
        inst_ready = 1'b1;
        if ((state_q == FILL) || (state_q == RUN)) begin
            inst_ready = shift_en;
        end
        accept          = inst_valid_i && inst_ready;
        dup             = nc_q.valid && (iaddr_i == nc_q.iaddr) && !exception_i;
        beat            = '0;
        beat.valid      = 1'b1;
        beat.iaddr      = iaddr_i;
        beat.inst_data  = inst_data_i;
        beat.compressed = compressed_i;
        beat.exception  = exception_i;
    end

    // Next-state, first-flag and stage shift control.
    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        stage_en = 1'b0;
        lc_d     = tc_q;
        tc_d     = nc_q;
        nc_d     = beat;

        if (step_hs) begin
            first_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = FILL;
                    first_d = 1'b1;
                end
            end
            FILL, RUN: begin
                if (!enable_i) begin
                    // Disable wins over a same-cycle beat; the beat is dropped.
                    state_d = (tc_q.valid || nc_q.valid) ? DRAIN : IDLE;
                end else begin
                    if (accept && !dup) begin
                        stage_en = 1'b1;
                    end
                    if ((state_q == FILL) && tc_q.valid && nc_q.valid) begin
                        state_d = RUN;
                    end
                end
            end
            DRAIN: begin
                if ((!tc_q.valid && !nc_q.valid) || (step_hs && last)) begin
                    // Final step taken (or nothing left): empty the window.
                    state_d  = IDLE;
                    stage_en = 1'b1;
                    lc_d     = stage_invalidate(lc_q);
                    tc_d     = stage_invalidate(tc_q);
                    nc_d     = stage_invalidate(nc_q);
                end else if (shift_en) begin
                    stage_en = 1'b1;
                    nc_d     = stage_invalidate(nc_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and first-instruction flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    trdb_stage_reg u_lc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (stage_en),
        .d_i    (lc_d),
        .q_o    (lc_q)
    );

    trdb_stage_reg u_tc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (stage_en),
        .d_i    (tc_d),
        .q_o    (tc_q)
    );

    trdb_stage_reg u_nc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (stage_en),
        .d_i    (nc_d),
        .q_o    (nc_q)
    );

    // Outputs are forced low for as long as reset is held.
    always_comb begin
        inst_ready_o    = rst_ni && inst_ready;
        lc_valid_o      = rst_ni && lc_q.valid;
        tc_ready_o      = rst_ni && tc_q.valid;
        nc_ready_o      = rst_ni && nc_q.valid;
        tc_iaddr_o      = rst_ni ? tc_q.iaddr : '0;
        tc_compressed_o = rst_ni && tc_q.compressed;
        nc_iaddr_o      = rst_ni ? nc_q.iaddr : '0;
        nc_inst_data_o  = rst_ni ? nc_q.inst_data : '0;
        nc_exception_o  = rst_ni && nc_q.exception;
        step_valid_o    = rst_ni && step_valid;
        first_o         = rst_ni && step_valid && first_q;
        last_o          = rst_ni && last;
    end

endmodule

// File: tb/tb_trdb_stage_ctrl.sv
// Directed bench for trdb_stage_ctrl: fill/first step, backpressure,
// duplicate drop, drain, re-enable during drain and reset mid-run.
module tb_trdb_stage_ctrl;

    localparam int XLEN = 32;

    logic            clk_i;
    logic            rst_ni;
    logic            enable_i;
    logic            inst_valid_i;
    logic            inst_ready_o;
    logic [XLEN-1:0] inst_data_i;
    logic [XLEN-1:0] iaddr_i;
    logic            compressed_i;
    logic            exception_i;
    logic            lc_valid_o;
    logic            tc_ready_o;
    logic            nc_ready_o;
    logic [XLEN-1:0] tc_iaddr_o;
    logic            tc_compressed_o;
    logic [XLEN-1:0] nc_iaddr_o;
    logic [XLEN-1:0] nc_inst_data_o;
    logic            nc_exception_o;
    logic            step_valid_o;
    logic            step_ready_i;
    logic            first_o;
    logic            last_o;

    int checks;
    int failures;

    trdb_stage_ctrl #(.XLEN(XLEN)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .enable_i        (enable_i),
        .inst_valid_i    (inst_valid_i),
        .inst_ready_o    (inst_ready_o),
        .inst_data_i     (inst_data_i),
        .iaddr_i         (iaddr_i),
        .compressed_i    (compressed_i),
        .exception_i     (exception_i),
        .lc_valid_o      (lc_valid_o),
        .tc_ready_o      (tc_ready_o),
        .nc_ready_o      (nc_ready_o),
        .tc_iaddr_o      (tc_iaddr_o),
        .tc_compressed_o (tc_compressed_o),
        .nc_iaddr_o      (nc_iaddr_o),
        .nc_inst_data_o  (nc_inst_data_o),
        .nc_exception_o  (nc_exception_o),
        .step_valid_o    (step_valid_o),
        .step_ready_i    (step_ready_i),
        .first_o         (first_o),
        .last_o          (last_o)
    );

    // Clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one retire beat (held until changed).
    task automatic drive_beat(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data,
                              input logic c, input logic exc);
        inst_valid_i = 1'b1;
        iaddr_i      = addr;
        inst_data_i  = data;
        compressed_i = c;
        exception_i  = exc;
    endtask

    task automatic idle_beat();
        inst_valid_i = 1'b0;
        exception_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; enable_i = 1'b0; step_ready_i = 1'b0;
        inst_valid_i = 1'b0; iaddr_i = '0; inst_data_i = '0;
        compressed_i = 1'b0; exception_i = 1'b0;
        tick(); tick();
        checks++; if (inst_ready_o !== 1'b0) begin failures++; $display("FAIL reset_inst_ready got=%b exp=0", inst_ready_o); end
        checks++; if (step_valid_o !== 1'b0) begin failures++; $display("FAIL reset_step_valid got=%b exp=0", step_valid_o); end
        checks++; if ({lc_valid_o, tc_ready_o, nc_ready_o} !== 3'b000) begin failures++; $display("FAIL reset_valids got=%b exp=000", {lc_valid_o, tc_ready_o, nc_ready_o}); end
        checks++; if ({first_o, last_o} !== 2'b00) begin failures++; $display("FAIL reset_first_last got=%b exp=00", {first_o, last_o}); end
        rst_ni = 1'b1;
        #1;
        checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL reset_idle_ready got=%b exp=1", inst_ready_o); end
    endtask

    task automatic test_fill_first();
        enable_i = 1'b1; step_ready_i = 1'b1;
        tick();
        checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready got=%b exp=1", inst_ready_o); end
        drive_beat(32'h100, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        checks++; if ({tc_ready_o, nc_ready_o, step_valid_o} !== 3'b010) begin failures++; $display("FAIL fill_one_beat got=%b exp=010", {tc_ready_o, nc_ready_o, step_valid_o}); end
        drive_beat(32'h104, 32'h0000_4505, 1'b1, 1'b0);
        tick();
        checks++; if (step_valid_o !== 1'b1) begin failures++; $display("FAIL fill_step_valid got=%b exp=1", step_valid_o); end
        checks++; if (tc_iaddr_o !== 32'h100) begin failures++; $display("FAIL fill_tc_iaddr got=%h exp=%h", tc_iaddr_o, 32'h100); end
        checks++; if (nc_iaddr_o !== 32'h104) begin failures++; $display("FAIL fill_nc_iaddr got=%h exp=%h", nc_iaddr_o, 32'h104); end
        checks++; if (nc_inst_data_o !== 32'h0000_4505) begin failures++; $display("FAIL fill_nc_data got=%h exp=%h", nc_inst_data_o, 32'h0000_4505); end
        checks++; if (tc_compressed_o !== 1'b0) begin failures++; $display("FAIL fill_tc_compressed got=%b exp=0", tc_compressed_o); end
        checks++; if (first_o !== 1'b1) begin failures++; $display("FAIL fill_first_set got=%b exp=1", first_o); end
        idle_beat();
        tick();
        checks++; if ({step_valid_o, first_o} !== 2'b10) begin failures++; $display("FAIL fill_first_clear got=%b exp=10", {step_valid_o, first_o}); end
    endtask

    task automatic test_backpressure();
        step_ready_i = 1'b0;
        drive_beat(32'h108, 32'h0000_0013, 1'b0, 1'b0);
        #1;
        checks++; if (inst_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", inst_ready_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (inst_ready_o !== 1'b0 || tc_iaddr_o !== 32'h100 || nc_iaddr_o !== 32'h104 || lc_valid_o !== 1'b0 || step_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got rdy=%b tc=%h nc=%h lc=%b sv=%b exp rdy=0 tc=100 nc=104 lc=0 sv=1",
                         i, inst_ready_o, tc_iaddr_o, nc_iaddr_o, lc_valid_o, step_valid_o);
            end
        end
        step_ready_i = 1'b1;
        #1;
        checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", inst_ready_o); end
        tick();
        checks++; if (tc_iaddr_o !== 32'h104 || nc_iaddr_o !== 32'h108 || lc_valid_o !== 1'b1 || tc_compressed_o !== 1'b1) begin failures++; $display("FAIL bp_release_shift got tc=%h nc=%h lc=%b c=%b exp tc=104 nc=108 lc=1 c=1", tc_iaddr_o, nc_iaddr_o, lc_valid_o, tc_compressed_o); end
        drive_beat(32'h10C, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        checks++; if (tc_iaddr_o !== 32'h108 || nc_iaddr_o !== 32'h10C) begin failures++; $display("FAIL bp_next_shift got tc=%h nc=%h exp tc=108 nc=10c", tc_iaddr_o, nc_iaddr_o); end
    endtask

    task automatic test_duplicate();
        drive_beat(32'h200, 32'h0000_0113, 1'b0, 1'b0);
        tick();
        drive_beat(32'h200, 32'h0000_0113, 1'b0, 1'b0);
        tick();
        checks++; if (tc_iaddr_o !== 32'h10C || nc_iaddr_o !== 32'h200) begin failures++; $display("FAIL dup_dropped got tc=%h nc=%h exp tc=10c nc=200", tc_iaddr_o, nc_iaddr_o); end
        drive_beat(32'h204, 32'h0000_0213, 1'b0, 1'b0);
        tick();
        checks++; if (tc_iaddr_o !== 32'h200 || nc_iaddr_o !== 32'h204) begin failures++; $display("FAIL dup_next got tc=%h nc=%h exp tc=200 nc=204", tc_iaddr_o, nc_iaddr_o); end
        drive_beat(32'h208, 32'h0000_0313, 1'b0, 1'b0);
        tick();
        drive_beat(32'h208, 32'h0000_0073, 1'b0, 1'b1);
        tick();
        checks++; if (tc_iaddr_o !== 32'h208 || nc_iaddr_o !== 32'h208 || nc_exception_o !== 1'b1) begin failures++; $display("FAIL dup_exc_kept got tc=%h nc=%h exc=%b exp tc=208 nc=208 exc=1", tc_iaddr_o, nc_iaddr_o, nc_exception_o); end
        idle_beat();
    endtask

    task automatic test_drain();
        drive_beat(32'h300, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        drive_beat(32'h304, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        idle_beat();
        step_ready_i = 1'b0; enable_i = 1'b0;
        tick();
        checks++; if (step_valid_o !== 1'b1 || tc_iaddr_o !== 32'h300 || last_o !== 1'b0 || nc_ready_o !== 1'b1) begin failures++; $display("FAIL drain_step1 got sv=%b tc=%h last=%b nc=%b exp sv=1 tc=300 last=0 nc=1", step_valid_o, tc_iaddr_o, last_o, nc_ready_o); end
        checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL drain_ready got=%b exp=1", inst_ready_o); end
        step_ready_i = 1'b1;
        tick();
        checks++; if (step_valid_o !== 1'b1 || tc_iaddr_o !== 32'h304 || nc_ready_o !== 1'b0 || last_o !== 1'b1) begin failures++; $display("FAIL drain_step2 got sv=%b tc=%h nc=%b last=%b exp sv=1 tc=304 nc=0 last=1", step_valid_o, tc_iaddr_o, nc_ready_o, last_o); end
        tick();
        checks++; if ({lc_valid_o, tc_ready_o, nc_ready_o, step_valid_o} !== 4'b0000) begin failures++; $display("FAIL drain_idle_valids got=%b exp=0000", {lc_valid_o, tc_ready_o, nc_ready_o, step_valid_o}); end
        checks++; if (tc_iaddr_o !== 32'h304) begin failures++; $display("FAIL drain_data_kept got=%h exp=%h", tc_iaddr_o, 32'h304); end
    endtask

    task automatic test_reenable_drain();
        step_ready_i = 1'b0; enable_i = 1'b1;
        tick();
        drive_beat(32'h400, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        drive_beat(32'h404, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        idle_beat();
        checks++; if (step_valid_o !== 1'b1 || first_o !== 1'b1 || tc_iaddr_o !== 32'h400) begin failures++; $display("FAIL reen_fill got sv=%b first=%b tc=%h exp sv=1 first=1 tc=400", step_valid_o, first_o, tc_iaddr_o); end
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1; step_ready_i = 1'b1;
        checks++; if (step_valid_o !== 1'b1 || last_o !== 1'b0 || tc_iaddr_o !== 32'h400) begin failures++; $display("FAIL reen_drain_step1 got sv=%b last=%b tc=%h exp sv=1 last=0 tc=400", step_valid_o, last_o, tc_iaddr_o); end
        tick();
        checks++; if (last_o !== 1'b1 || tc_iaddr_o !== 32'h404 || first_o !== 1'b0) begin failures++; $display("FAIL reen_drain_last got last=%b tc=%h first=%b exp last=1 tc=404 first=0", last_o, tc_iaddr_o, first_o); end
        tick();
        checks++; if ({tc_ready_o, step_valid_o, inst_ready_o} !== 3'b001) begin failures++; $display("FAIL reen_idle got=%b exp=001", {tc_ready_o, step_valid_o, inst_ready_o}); end
        step_ready_i = 1'b0;
        tick();
        drive_beat(32'h500, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        drive_beat(32'h504, 32'h0000_0093, 1'b0, 1'b0);
        tick();
        checks++; if (step_valid_o !== 1'b1 || first_o !== 1'b1 || tc_iaddr_o !== 32'h500) begin failures++; $display("FAIL reen_first got sv=%b first=%b tc=%h exp sv=1 first=1 tc=500", step_valid_o, first_o, tc_iaddr_o); end
    endtask

    task automatic test_reset_mid();
        drive_beat(32'h508, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        checks++; if (inst_ready_o !== 1'b0 || nc_iaddr_o !== 32'h504) begin failures++; $display("FAIL rst_pre_hold got rdy=%b nc=%h exp rdy=0 nc=504", inst_ready_o, nc_iaddr_o); end
        rst_ni = 1'b0;
        tick();
        checks++; if ({inst_ready_o, lc_valid_o, tc_ready_o, nc_ready_o, step_valid_o, first_o, last_o} !== 7'b0) begin failures++; $display("FAIL rst_mid_flags got=%b exp=0000000", {inst_ready_o, lc_valid_o, tc_ready_o, nc_ready_o, step_valid_o, first_o, last_o}); end
        checks++; if (tc_iaddr_o !== 32'h0 || nc_iaddr_o !== 32'h0) begin failures++; $display("FAIL rst_mid_data got tc=%h nc=%h exp 0", tc_iaddr_o, nc_iaddr_o); end
        rst_ni = 1'b1; enable_i = 1'b0;
        idle_beat();
        #1;
        checks++; if (inst_ready_o !== 1'b1 || tc_ready_o !== 1'b0) begin failures++; $display("FAIL rst_release_idle got rdy=%b tc=%b exp rdy=1 tc=0", inst_ready_o, tc_ready_o); end
        checks++; if (tc_iaddr_o !== 32'h0 || nc_iaddr_o !== 32'h0 || nc_inst_data_o !== 32'h0) begin failures++; $display("FAIL rst_release_data got tc=%h nc=%h d=%h exp 0", tc_iaddr_o, nc_iaddr_o, nc_inst_data_o); end
        tick();
        checks++; if (step_valid_o !== 1'b0 || inst_ready_o !== 1'b1) begin failures++; $display("FAIL rst_stay_idle got sv=%b rdy=%b exp sv=0 rdy=1", step_valid_o, inst_ready_o); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fill_first();
        test_backpressure();
        test_duplicate();
        test_drain();
        test_reenable_drain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
